// File: rtl/rs_queue.sv
// Reservation station: age-ordered wakeup/select feeding a registered
// valid/ready issue port, with flush and occupancy count.
module rs_queue #(
    parameter int ENTRIES = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 3,
    parameter int OP_W    = 5,
    parameter int IMM_W   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [OP_W-1:0]                disp_op,
    input  logic [TAG_W-1:0]               disp_des,
    input  logic [DATA_W-1:0]              disp_v1,
    input  logic [DATA_W-1:0]              disp_v2,
    input  logic [TAG_W-1:0]               disp_q1,
    input  logic [TAG_W-1:0]               disp_q2,
    input  logic [IMM_W-1:0]               disp_imm,
    input  logic [TAG_W-1:0]               cdb0_tag,
    input  logic [DATA_W-1:0]              cdb0_data,
    input  logic [TAG_W-1:0]               cdb1_tag,
    input  logic [DATA_W-1:0]              cdb1_data,
    output logic                           iss_valid,
    input  logic                           iss_ready,
    output logic [OP_W-1:0]                iss_op,
    output logic [TAG_W-1:0]               iss_des,
    output logic [DATA_W-1:0]              iss_v1,
    output logic [DATA_W-1:0]              iss_v2,
    output logic [IMM_W-1:0]               iss_imm,
    output logic [$clog2(ENTRIES+1)-1:0]   count,
    output logic                           full
);

    localparam int AW = $clog2(ENTRIES);
    localparam int CW = $clog2(ENTRIES+1);
    localparam logic [AW-1:0] AGE_ONE = AW'(1);

    logic [ENTRIES-1:0] busy;
    logic [OP_W-1:0]    e_op  [ENTRIES];
    logic [TAG_W-1:0]   e_des [ENTRIES];
    logic [DATA_W-1:0]  e_v1  [ENTRIES];
    logic [DATA_W-1:0]  e_v2  [ENTRIES];
    logic [TAG_W-1:0]   e_q1  [ENTRIES];
    logic [TAG_W-1:0]   e_q2  [ENTRIES];
    logic [IMM_W-1:0]   e_imm [ENTRIES];
    logic [AW-1:0]      e_age [ENTRIES];
    logic [AW-1:0]      age_nxt [ENTRIES];

    logic              disp_fire;
    logic              can_load;
    logic              move;
    logic              sel_found;
    logic [AW-1:0]     sel_idx;
    logic [AW-1:0]     sel_age;
    logic [AW-1:0]     free_idx;
    logic [DATA_W-1:0] cap_v1, cap_v2;
    logic [TAG_W-1:0]  cap_q1, cap_q2;

    always_comb begin
        count = '0;
        for (int i = 0; i < ENTRIES; i++)
            count = count + CW'(busy[i]);
    end

    assign full       = (count == CW'(ENTRIES));
    assign disp_ready = rst && !flush && !full;
    assign disp_fire  = disp_valid && disp_ready;
    assign can_load   = !iss_valid || iss_ready;
    assign move       = can_load && sel_found;

    // Oldest ready entry, judged on registered state only.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (busy[i] && e_q1[i] == '0 && e_q2[i] == '0 &&
                (!sel_found || e_age[i] > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = AW'(i);
                sel_age   = e_age[i];
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES-1; i >= 0; i--)
            if (!busy[i]) free_idx = AW'(i);
    end

    // Ages are compacted on issue so they stay within 0..count-1.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            age_nxt[i] = e_age[i];
            if (move && e_age[i] > e_age[sel_idx])
                age_nxt[i] = age_nxt[i] - AGE_ONE;
            if (disp_fire)
                age_nxt[i] = age_nxt[i] + AGE_ONE;
        end
    end

    always_comb begin
        cap_v1 = '0;
        cap_q1 = disp_q1;
        if (disp_q1 == '0) begin
            cap_v1 = disp_v1;
        end else if (disp_q1 == cdb0_tag) begin
            cap_v1 = cdb0_data;
            cap_q1 = '0;
        end else if (disp_q1 == cdb1_tag) begin
            cap_v1 = cdb1_data;
            cap_q1 = '0;
        end
        cap_v2 = '0;
        cap_q2 = disp_q2;
        if (disp_q2 == '0) begin
            cap_v2 = disp_v2;
        end else if (disp_q2 == cdb0_tag) begin
            cap_v2 = cdb0_data;
            cap_q2 = '0;
        end else if (disp_q2 == cdb1_tag) begin
            cap_v2 = cdb1_data;
            cap_q2 = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy      <= '0;
            iss_valid <= 1'b0;
            iss_op    <= '0;
            iss_des   <= '0;
            iss_v1    <= '0;
            iss_v2    <= '0;
            iss_imm   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                e_op[i]  <= '0;
                e_des[i] <= '0;
                e_v1[i]  <= '0;
                e_v2[i]  <= '0;
                e_q1[i]  <= '0;
                e_q2[i]  <= '0;
                e_imm[i] <= '0;
                e_age[i] <= '0;
            end
        end else if (flush) begin
            busy      <= '0;
            iss_valid <= 1'b0;
            for (int i = 0; i < ENTRIES; i++)
                e_age[i] <= '0;
        end else begin
            if (can_load) begin
                iss_valid <= sel_found;
                if (sel_found) begin
                    iss_op  <= e_op[sel_idx];
                    iss_des <= e_des[sel_idx];
                    iss_v1  <= e_v1[sel_idx];
                    iss_v2  <= e_v2[sel_idx];
                    iss_imm <= e_imm[sel_idx];
                end
            end
            for (int i = 0; i < ENTRIES; i++) begin
                if (busy[i]) begin
                    if (e_q1[i] != '0) begin
                        if (e_q1[i] == cdb0_tag) begin
                            e_v1[i] <= cdb0_data;
                            e_q1[i] <= '0;
                        end else if (e_q1[i] == cdb1_tag) begin
                            e_v1[i] <= cdb1_data;
                            e_q1[i] <= '0;
                        end
                    end
                    if (e_q2[i] != '0) begin
                        if (e_q2[i] == cdb0_tag) begin
                            e_v2[i] <= cdb0_data;
                            e_q2[i] <= '0;
                        end else if (e_q2[i] == cdb1_tag) begin
                            e_v2[i] <= cdb1_data;
                            e_q2[i] <= '0;
                        end
                    end
                    e_age[i] <= age_nxt[i];
                    if (move && sel_idx == AW'(i))
                        busy[i] <= 1'b0;
                end
            end
            if (disp_fire) begin
                busy[free_idx]  <= 1'b1;
                e_op[free_idx]  <= disp_op;
                e_des[free_idx] <= disp_des;
                e_v1[free_idx]  <= cap_v1;
                e_v2[free_idx]  <= cap_v2;
                e_q1[free_idx]  <= cap_q1;
                e_q2[free_idx]  <= cap_q2;
                e_imm[free_idx] <= disp_imm;
                e_age[free_idx] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rs_queue.sv
// Directed bench for rs_queue: vector table for single-entry flows,
// hand sequences for age order, full/backpressure and flush.
module tb_rs_queue;

    logic        clk = 1'b0;
    logic        rst, flush, disp_valid, disp_ready;
    logic [4:0]  disp_op;
    logic [2:0]  disp_des, disp_q1, disp_q2;
    logic [31:0] disp_v1, disp_v2, disp_imm;
    logic [2:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_data, cdb1_data;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_op;
    logic [2:0]  iss_des;
    logic [31:0] iss_v1, iss_v2, iss_imm;
    logic [2:0]  count;
    logic        full;

    int checks = 0;
    int errors = 0;

    rs_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op), .disp_des(disp_des),
        .disp_v1(disp_v1), .disp_v2(disp_v2),
        .disp_q1(disp_q1), .disp_q2(disp_q2),
        .disp_imm(disp_imm),
        .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_des(iss_des),
        .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_imm(iss_imm),
        .count(count), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [2:0]  des, q1, q2;
        logic [31:0] v1, v2;
        logic [2:0]  c0t, c1t;
        logic [31:0] c0d, c1d;
        logic        e_iv;
        logic [2:0]  e_des;
        logic [31:0] e_v1, e_v2;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(
        logic dv, logic [2:0] des, logic [2:0] q1, logic [31:0] v1,
        logic [2:0] q2, logic [31:0] v2,
        logic [2:0] c0t, logic [31:0] c0d,
        logic [2:0] c1t, logic [31:0] c1d,
        logic e_iv, logic [2:0] e_des, logic [31:0] e_v1,
        logic [31:0] e_v2, logic [2:0] e_cnt);
        vec_t v;
        v.dv = dv; v.des = des; v.q1 = q1; v.v1 = v1;
        v.q2 = q2; v.v2 = v2;
        v.c0t = c0t; v.c0d = c0d; v.c1t = c1t; v.c1d = c1d;
        v.e_iv = e_iv; v.e_des = e_des;
        v.e_v1 = e_v1; v.e_v2 = e_v2; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drv(logic dv, logic [2:0] des, logic [2:0] q1,
                       logic [31:0] v1, logic [2:0] q2, logic [31:0] v2);
        disp_valid = dv;
        disp_des   = des;
        disp_op    = {2'b01, des};
        disp_imm   = 32'hC0DE0000 | {29'h0, des};
        disp_q1    = q1;
        disp_v1    = v1;
        disp_q2    = q2;
        disp_v2    = v2;
    endtask

    task automatic cdb(logic [2:0] t0, logic [31:0] d0,
                       logic [2:0] t1, logic [31:0] d1);
        cdb0_tag = t0; cdb0_data = d0;
        cdb1_tag = t1; cdb1_data = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        iss_ready = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        cdb(0, 0, 0, 0);

        vt[0]  = mk(1, 3, 0, 5, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 5, 7, 0);
        vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[3]  = mk(1, 5, 2, 'h99, 0, 1, 0, 0, 2, 'hAB, 0, 0, 0, 0, 1);
        vt[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 'hAB, 1, 0);
        vt[5]  = mk(1, 6, 0, 3, 4, 'h55, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 4, 'h11, 0, 0, 0, 0, 0, 0, 1);
        vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 3, 'h11, 0);
        vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[11] = mk(1, 7, 6, 0, 6, 0, 6, 'h22, 6, 'h33, 0, 0, 0, 0, 1);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 'h22, 'h22, 0);
        vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[14] = mk(1, 1, 3, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[15] = mk(0, 0, 0, 0, 0, 0, 3, 'h44, 5, 'h66, 0, 0, 0, 0, 1);
        vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h44, 'h66, 0);
        vt[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset
        tick();
        tick();
        chk("rst_iss_valid", 64'(iss_valid), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_full", 64'(full), 0);
        chk("rst_disp_ready", 64'(disp_ready), 0);
        chk("rst_iss_des", 64'(iss_des), 0);
        chk("rst_iss_v1", 64'(iss_v1), 0);
        rst = 1'b1;
        tick();
        chk("post_rst_disp_ready", 64'(disp_ready), 1);

        // vector table
        for (int r = 0; r < 18; r++) begin
            drv(vt[r].dv, vt[r].des, vt[r].q1, vt[r].v1,
                vt[r].q2, vt[r].v2);
            cdb(vt[r].c0t, vt[r].c0d, vt[r].c1t, vt[r].c1d);
            tick();
            chk($sformatf("v%0d_iss_valid", r), 64'(iss_valid),
                64'(vt[r].e_iv));
            chk($sformatf("v%0d_count", r), 64'(count),
                64'(vt[r].e_cnt));
            if (vt[r].e_iv) begin
                chk($sformatf("v%0d_des", r), 64'(iss_des),
                    64'(vt[r].e_des));
                chk($sformatf("v%0d_op", r), 64'(iss_op),
                    64'({2'b01, vt[r].e_des}));
                chk($sformatf("v%0d_imm", r), 64'(iss_imm),
                    64'(32'hC0DE0000 | {29'h0, vt[r].e_des}));
                chk($sformatf("v%0d_v1", r), 64'(iss_v1),
                    64'(vt[r].e_v1));
                chk($sformatf("v%0d_v2", r), 64'(iss_v2),
                    64'(vt[r].e_v2));
            end
        end
        drv(0, 0, 0, 0, 0, 0);
        cdb(0, 0, 0, 0);

        // age order: X parks in issue reg, then A(waiting), B, C
        iss_ready = 1'b0;
        drv(1, 7, 0, 'h70, 0, 0);
        tick();
        chk("age_x_count", 64'(count), 1);
        drv(1, 1, 5, 0, 0, 'h10);
        tick();
        chk("age_x_issued", 64'(iss_des), 7);
        chk("age_x_count2", 64'(count), 1);
        drv(1, 2, 0, 'h20, 0, 0);
        tick();
        drv(1, 3, 0, 'h30, 0, 0);
        tick();
        chk("age_count3", 64'(count), 3);
        drv(0, 0, 0, 0, 0, 0);
        cdb(5, 'h55, 0, 0);
        tick();
        chk("age_hold_des", 64'(iss_des), 7);
        cdb(0, 0, 0, 0);
        iss_ready = 1'b1;
        tick();
        chk("age_first_des", 64'(iss_des), 1);
        chk("age_first_v1", 64'(iss_v1), 'h55);
        chk("age_first_v2", 64'(iss_v2), 'h10);
        tick();
        chk("age_second_des", 64'(iss_des), 2);
        tick();
        chk("age_third_des", 64'(iss_des), 3);
        chk("age_third_count", 64'(count), 0);
        tick();
        chk("age_empty_valid", 64'(iss_valid), 0);

        // full and backpressure
        iss_ready = 1'b0;
        drv(1, 1, 0, 1, 0, 1);
        tick();
        drv(1, 2, 0, 2, 0, 2);
        tick();
        chk("full_move_count", 64'(count), 1);
        chk("full_iss_des", 64'(iss_des), 1);
        for (int k = 3; k <= 5; k++) begin
            drv(1, 3'(k), 0, 32'(k), 0, 32'(k));
            tick();
        end
        chk("full_count", 64'(count), 4);
        chk("full_flag", 64'(full), 1);
        drv(1, 6, 0, 6, 0, 6);
        #1;
        chk("full_disp_ready", 64'(disp_ready), 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("bp%0d_des", k), 64'(iss_des), 1);
            chk($sformatf("bp%0d_count", k), 64'(count), 4);
        end
        chk("bp_valid", 64'(iss_valid), 1);
        chk("bp_v1", 64'(iss_v1), 1);
        drv(0, 0, 0, 0, 0, 0);
        iss_ready = 1'b1;
        tick();
        chk("drain_des", 64'(iss_des), 2);
        chk("drain_count", 64'(count), 3);

        // flush with a same-cycle dispatch
        iss_ready = 1'b0;
        flush = 1'b1;
        drv(1, 6, 0, 'h66, 0, 0);
        #1;
        chk("flush_disp_ready", 64'(disp_ready), 0);
        tick();
        chk("flush_count", 64'(count), 0);
        chk("flush_valid", 64'(iss_valid), 0);
        flush = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post_flush%0d_valid", k), 64'(iss_valid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
